// File: rtl/alu_ctl_pkg.sv
// Shared ALU control encodings and the mul/div sequencer state type.
package alu_ctl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_DIV = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> mul/div sequencer handshake and result bus.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             Start;
  logic [3:0]       ALUControlInput;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic             Flush;
  logic             Stall;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ResultLo;
  logic [WIDTH-1:0] ResultHi;
  logic             DivByZero;

  modport master (
    output Start, ALUControlInput, OperandA, OperandB, Flush,
    input  Stall, Busy, Done, ResultLo, ResultHi, DivByZero
  );

  modport slave (
    input  Start, ALUControlInput, OperandA, OperandB, Flush,
    output Stall, Busy, Done, ResultLo, ResultHi, DivByZero
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide on a 2W+1-bit accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             op_div,
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH-1:0] b,
  output logic [2*WIDTH:0] acc_next,
  output logic             qbit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  // Multiply: acc = {0, partial product hi, remaining multiplier bits}; add then shift right.
  // Divide:   acc = {0, remainder, remaining dividend bits}; shift left, trial-subtract B.
  always_comb begin
    sum   = acc[2*WIDTH:WIDTH] + {1'b0, b};
    trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b};
    qbit  = 1'b0;
    if (op_div) begin
      qbit = ~trial[WIDTH];
      if (qbit) acc_next = {trial, acc[WIDTH-2:0], 1'b1};
      else      acc_next = {acc[2*WIDTH-1:0], 1'b0};
    end else begin
      acc_next = {1'b0, (acc[0] ? sum : acc[2*WIDTH:WIDTH]), acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mul/div sequencer: stalls EX while iterating, then pulses Done with {Hi, Lo}.
module muldiv_sequencer
  import alu_ctl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  seq_state_e       state, state_d;
  logic [CW-1:0]    count, count_d;
  logic [2*WIDTH:0] acc, acc_d, step_acc;
  logic [WIDTH-1:0] opnd, opnd_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic             dbz_q, dbz_d;
  logic             step_qbit;
  logic             is_mul, is_div;

  assign is_mul = (bus.ALUControlInput == ALU_MUL);
  assign is_div = (bus.ALUControlInput == ALU_DIV);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_div   (state == ST_DIV),
    .acc      (acc),
    .b        (opnd),
    .acc_next (step_acc),
    .qbit     (step_qbit)
  );

  // NOTE: every output of this block is given a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    count_d = count;
    acc_d   = acc;
    opnd_d  = opnd;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dbz_d   = dbz_q;
    unique case (state)
      ST_IDLE: begin
        if (bus.Start && !bus.Flush && is_mul) begin
          acc_d   = {{(WIDTH+1){1'b0}}, bus.OperandB};
          opnd_d  = bus.OperandA;
          count_d = CW'(WIDTH);
          dbz_d   = 1'b0;
          state_d = ST_MUL;
        end else if (bus.Start && !bus.Flush && is_div) begin
          if (bus.OperandB == '0) begin
            lo_d    = '1;
            hi_d    = bus.OperandA;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            acc_d   = {{(WIDTH+1){1'b0}}, bus.OperandA};
            opnd_d  = bus.OperandB;
            count_d = CW'(WIDTH);
            dbz_d   = 1'b0;
            state_d = ST_DIV;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d   = step_acc;
        count_d = count - 1'b1;
        if (bus.Flush) begin
          state_d = ST_IDLE;
        end else if (count == CW'(1)) begin
          // The last step's result goes straight into the result registers for the Done cycle.
          hi_d    = step_acc[2*WIDTH-1:WIDTH];
          lo_d    = (state == ST_DIV) ? {step_acc[WIDTH-1:1], step_qbit} : step_acc[WIDTH-1:0];
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      acc   <= '0;
      opnd  <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
      dbz_q <= 1'b0;
    end else begin
      state <= state_d;
      count <= count_d;
      acc   <= acc_d;
      opnd  <= opnd_d;
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      dbz_q <= dbz_d;
    end
  end

  assign bus.Busy      = (state == ST_MUL) || (state == ST_DIV);
  assign bus.Done      = (state == ST_DONE);
  assign bus.Stall     = ((state == ST_IDLE) && bus.Start && (is_mul || is_div)) || bus.Busy;
  assign bus.ResultLo  = lo_q;
  assign bus.ResultHi  = hi_q;
  assign bus.DivByZero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, stall window, results, div-by-zero, flush, reset.
module tb_muldiv_sequencer;
  import alu_ctl_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Observations gathered by run()
  int          done_cyc, done_cnt, stall_cnt;
  logic        stall0;
  logic [31:0] d_lo, d_hi;
  logic        d_dbz;
  logic        s_busy, s_done, s_stall, s_dbz;
  logic [31:0] s_lo, s_hi;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start is high in cycle 0 only (plus an optional mid-op restart with a different mul).
  // Each cycle is driven at the falling edge and sampled 1 ns later.
  task automatic run(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                     input int flush_at, input int reset_at, input int restart_at,
                     input int snap_at);
    done_cyc  = -1;
    done_cnt  = 0;
    stall_cnt = 0;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      bus.Start           = (i == 0) || (i == restart_at);
      bus.ALUControlInput = (i == restart_at) ? ALU_MUL : code;
      bus.OperandA        = (i == 0) ? a : 32'd3;
      bus.OperandB        = (i == 0) ? b : 32'd3;
      bus.Flush           = (i == flush_at);
      reset               = (i == reset_at);
      #1;
      if (i == 0) stall0 = bus.Stall;
      else if (bus.Stall) stall_cnt++;
      if (bus.Done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = i;
          d_lo     = bus.ResultLo;
          d_hi     = bus.ResultHi;
          d_dbz    = bus.DivByZero;
        end
      end
      if (i == snap_at) begin
        s_busy  = bus.Busy;
        s_done  = bus.Done;
        s_stall = bus.Stall;
        s_lo    = bus.ResultLo;
        s_hi    = bus.ResultHi;
        s_dbz   = bus.DivByZero;
      end
    end
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    reset     = 1'b0;
  endtask

  initial begin
    reset               = 1'b1;
    bus.Start           = 1'b0;
    bus.ALUControlInput = ALU_ADD;
    bus.OperandA        = '0;
    bus.OperandB        = '0;
    bus.Flush           = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy",  bus.Busy,      0);
    check("rst_done",  bus.Done,      0);
    check("rst_stall", bus.Stall,     0);
    check("rst_lo",    bus.ResultLo,  0);
    check("rst_hi",    bus.ResultHi,  0);
    check("rst_dbz",   bus.DivByZero, 0);

    // mul 7*6: stall cycles 0..32, Done in cycle 33
    run(ALU_MUL, 32'd7, 32'd6, -1, -1, -1, -1);
    check("mul7x6_stall0", stall0,    1);
    check("mul7x6_stalls", stall_cnt, 32);
    check("mul7x6_donecy", done_cyc,  33);
    check("mul7x6_ndone",  done_cnt,  1);
    check("mul7x6_lo",     d_lo,      42);
    check("mul7x6_hi",     d_hi,      0);

    run(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1, -1);
    check("mulmax_lo",  d_lo,  32'h0000_0001);
    check("mulmax_hi",  d_hi,  32'hFFFF_FFFE);
    check("mulmax_dbz", d_dbz, 0);

    // div 100/7, then the cycle after Done
    run(ALU_DIV, 32'd100, 32'd7, -1, -1, -1, 34);
    check("div100_donecy", done_cyc, 33);
    check("div100_lo",     d_lo,     14);
    check("div100_hi",     d_hi,     2);
    check("div100_busy34", s_busy,   0);
    check("div100_done34", s_done,   0);
    check("div100_lo34",   s_lo,     14);
    check("div100_hi34",   s_hi,     2);

    run(ALU_DIV, 32'd5, 32'd0, -1, -1, -1, -1);
    check("div0_stall0", stall0,    1);
    check("div0_stalls", stall_cnt, 0);
    check("div0_donecy", done_cyc,  1);
    check("div0_dbz",    d_dbz,     1);
    check("div0_lo",     d_lo,      32'hFFFF_FFFF);
    check("div0_hi",     d_hi,      5);

    // Accepting a mul clears DivByZero immediately
    run(ALU_MUL, 32'd3, 32'd5, -1, -1, -1, 1);
    check("mul3x5_dbz1", s_dbz, 0);
    check("mul3x5_lo",   d_lo,  15);
    check("mul3x5_dbz",  d_dbz, 0);

    // Flush mid-mul: idle next cycle, no Done, results retain 15
    run(ALU_MUL, 32'd9, 32'd9, 10, -1, -1, 11);
    check("flush_busy11",  s_busy,   0);
    check("flush_stall11", s_stall,  0);
    check("flush_lo11",    s_lo,     15);
    check("flush_ndone",   done_cnt, 0);

    // Reset mid-mul: all outputs zero next cycle
    run(ALU_MUL, 32'd9, 32'd9, -1, 10, -1, 11);
    check("rstmid_busy11", s_busy,   0);
    check("rstmid_done11", s_done,   0);
    check("rstmid_lo11",   s_lo,     0);
    check("rstmid_hi11",   s_hi,     0);
    check("rstmid_ndone",  done_cnt, 0);

    // Non-mul/div code passes through
    run(ALU_ADD, 32'd1, 32'd2, -1, -1, -1, 1);
    check("add_stall0", stall0,   0);
    check("add_busy1",  s_busy,   0);
    check("add_ndone",  done_cnt, 0);

    // A new mul while busy is ignored
    run(ALU_MUL, 32'd7, 32'd6, -1, -1, 5, -1);
    check("restart_donecy", done_cyc, 33);
    check("restart_ndone",  done_cnt, 1);
    check("restart_lo",     d_lo,     42);

    run(ALU_DIV, 32'hFFFF_FFFF, 32'd1, -1, -1, -1, -1);
    check("divby1_lo", d_lo, 32'hFFFF_FFFF);
    check("divby1_hi", d_hi, 0);

    run(ALU_DIV, 32'd7, 32'd100, -1, -1, -1, -1);
    check("divsmall_lo", d_lo, 0);
    check("divsmall_hi", d_hi, 7);

    // Flush in IDLE blocks a same-cycle Start
    run(ALU_DIV, 32'd50, 32'd5, 0, -1, -1, 1);
    check("idleflush_busy1", s_busy,   0);
    check("idleflush_ndone", done_cnt, 0);
    check("idleflush_lo",    s_lo,     0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
